// File: rtl/rom_scan_if.sv
// Key, ROM and display signals of the ROM browse controller.
// master = controller side, slave = board/ROM/display side.
interface rom_scan_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              key1;
    logic              key2;
    logic              key3;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_vld;
    logic              auto_mode;
    logic              dir_down;

    modport master (
        input  key1, key2, key3, rom_data,
        output rom_addr, disp_addr, disp_data, disp_vld, auto_mode, dir_down
    );

    modport slave (
        output key1, key2, key3, rom_data,
        input  rom_addr, disp_addr, disp_data, disp_vld, auto_mode, dir_down
    );
endinterface

// File: rtl/rom_scan_ctrl.sv
// ROM browse controller: debounced keys step a ROM address manually or on a timer.
// Define ROM_SCAN_PINGPONG_EN to bounce at the ends in auto mode instead of wrapping.
module rom_scan_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [23:0] STEP_MAX = 24'd9_999_999,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    rom_scan_if.master  bus
);
    localparam logic [ADDR_W-1:0] Last = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StWait, StLatch} state_e;

    logic [2:0]       key_n;
    logic [2:0][1:0]  sync_q;
    logic [2:0][19:0] cnt_q;
    logic [2:0]       press;

    assign key_n = {bus.key3, bus.key2, bus.key1};

    for (genvar k = 0; k < 3; k++) begin : g_key
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync_q[k] <= 2'b11;
                cnt_q[k]  <= '0;
            end else begin
                sync_q[k] <= {sync_q[k][0], key_n[k]};
                if (sync_q[k][1]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] != CNT_MAX) begin
                    cnt_q[k] <= cnt_q[k] + 20'd1;
                end
            end
        end
        // Fires on the way to saturation, so a long hold yields one pulse.
        assign press[k] = ~sync_q[k][1] & (cnt_q[k] == CNT_MAX - 20'd1);
    end

    state_e            state_q;
    logic [1:0]        wait_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] disp_addr_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              disp_vld_q;
    logic              auto_q;
    logic              dir_q;
    logic [23:0]       step_q;

    logic              key_step, key_down, tick, step_req, step_down, move_down;
    logic              accept, dir_d, timer_clr;
    logic [ADDR_W-1:0] next_addr;

    always_comb begin
        key_step  = press[0] | press[1];
        key_down  = ~press[0] & press[1];
        tick      = auto_q & ~press[2] & (step_q == STEP_MAX);
        step_req  = key_step | tick;
        step_down = key_step ? key_down : dir_q;
        move_down = step_down;
`ifdef ROM_SCAN_PINGPONG_EN
        if (auto_q && !step_down && addr_q == Last) begin
            move_down = 1'b1;
        end else if (auto_q && step_down && addr_q == '0) begin
            move_down = 1'b0;
        end
`endif
        if (move_down) begin
            next_addr = (addr_q == '0) ? Last : addr_q - ADDR_W'(1);
        end else begin
            next_addr = (addr_q == Last) ? '0 : addr_q + ADDR_W'(1);
        end
        accept = step_req & (state_q == StIdle);
        // An accepted step fixes the direction it actually moved in (covers the bounce).
        if (accept) begin
            dir_d = move_down;
        end else if (key_step) begin
            dir_d = key_down;
        end else begin
            dir_d = dir_q;
        end
        timer_clr = ~auto_q | press[2] | key_step | tick;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StWait;
            wait_q      <= '0;
            addr_q      <= '0;
            disp_addr_q <= '0;
            disp_data_q <= '0;
            disp_vld_q  <= 1'b0;
            auto_q      <= 1'b0;
            dir_q       <= 1'b0;
            step_q      <= '0;
        end else begin
            disp_vld_q <= 1'b0;
            auto_q     <= auto_q ^ press[2];
            dir_q      <= dir_d;
            step_q     <= timer_clr ? '0 : step_q + 24'd1;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        addr_q  <= next_addr;
                        wait_q  <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (wait_q == 2'(RD_LAT)) begin
                        disp_data_q <= bus.rom_data;
                        disp_addr_q <= addr_q;
                        disp_vld_q  <= 1'b1;
                        state_q     <= StLatch;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                StLatch: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.disp_addr = disp_addr_q;
    assign bus.disp_data = disp_data_q;
    assign bus.disp_vld  = disp_vld_q;
    assign bus.auto_mode = auto_q;
    assign bus.dir_down  = dir_q;
endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl with a 2-cycle ROM model and a display scoreboard.
// Honours ROM_SCAN_PINGPONG_EN for the auto-scan expectations.
module tb_rom_scan_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    int   vld_cnt;
    int   last_vld_cyc;
    int   vld_cyc_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  rom_p1;

    rom_scan_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    rom_scan_ctrl #(
        .ADDR_W(8), .DATA_W(8), .DEPTH(16), .CNT_MAX(20'd99), .STEP_MAX(24'd999), .RD_LAT(2)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents A0+i, two-cycle read latency.
    always @(posedge clk) begin
        rom_p1       <= 8'hA0 + bus.rom_addr;
        bus.rom_data <= rom_p1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.disp_vld) begin
            logic [15:0] e;
            vld_cnt++;
            last_vld_cyc = cyc;
            vld_cyc_q.push_back(cyc);
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("disp_addr", 32'(bus.disp_addr), 32'(e[15:8]));
                chk("disp_data", 32'(bus.disp_data), 32'(e[7:0]));
            end
        end
    end

    task automatic expect_word(input int a);
        exp_q.push_back({8'(a), 8'hA0 + 8'(a)});
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            1: bus.key1 = v;
            2: bus.key2 = v;
            default: bus.key3 = v;
        endcase
    endtask

    task automatic press(input int k, output int t_low);
        @(negedge clk);
        set_key(k, 1'b0);
        t_low = cyc;
        repeat (150) @(negedge clk);
        set_key(k, 1'b1);
        repeat (150) @(negedge clk);
    endtask

    task automatic wait_vld(input int target, input int budget, input string tag);
        int n = 0;
        while (vld_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(vld_cnt), 32'(target));
    endtask

    initial begin
        int t;
        int rel;
        int base;
        int idx;
        errors = 0; checks = 0; vld_cnt = 0; cyc = 0; last_vld_cyc = 0;
        bus.key1 = 1'b1; bus.key2 = 1'b1; bus.key3 = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_disp_addr", 32'(bus.disp_addr), 32'd0);
        chk("rst_disp_data", 32'(bus.disp_data), 32'd0);
        chk("rst_vld", 32'(bus.disp_vld), 32'd0);
        chk("rst_auto", 32'(bus.auto_mode), 32'd0);
        chk("rst_dir", 32'(bus.dir_down), 32'd0);

        // Power-up fetch of address 0.
        expect_word(0);
        rst_n = 1'b1;
        rel = cyc;
        wait_vld(1, 20, "boot_vld");
        chk("boot_latency", 32'(last_vld_cyc - rel), 32'd3);

        // key1 with bounce, then a long hold: one step only.
        expect_word(1);
        @(negedge clk);
        bus.key1 = 1'b0; #40; bus.key1 = 1'b1; #60;
        bus.key1 = 1'b0; #200; bus.key1 = 1'b1; #20;
        bus.key1 = 1'b0;
        t = cyc;
        #3000;
        @(negedge clk);
        bus.key1 = 1'b1;
        repeat (300) @(negedge clk);
        chk("bounce_vld_count", 32'(vld_cnt), 32'd2);
        chk("bounce_latency", 32'(last_vld_cyc - t), 32'd104);
        chk("bounce_rom_addr", 32'(bus.rom_addr), 32'd1);

        // Manual stepping with wrap at both ends.
        expect_word(0);
        press(2, t);
        expect_word(15);
        press(2, t);
        chk("key2_latency", 32'(last_vld_cyc - t), 32'd104);
        chk("wrap_down_addr", 32'(bus.rom_addr), 32'd15);
        chk("wrap_down_dir", 32'(bus.dir_down), 32'd1);
        expect_word(0);
        press(1, t);
        chk("wrap_up_addr", 32'(bus.rom_addr), 32'd0);
        chk("wrap_up_dir", 32'(bus.dir_down), 32'd0);
        chk("manual_vld_count", 32'(vld_cnt), 32'd5);

        // Reach 14 with direction up.
        expect_word(15); press(2, t);
        expect_word(14); press(2, t);
        expect_word(13); press(2, t);
        expect_word(14); press(1, t);
        chk("pre_auto_addr", 32'(bus.rom_addr), 32'd14);

        // Auto scan.
        base = vld_cnt;
`ifdef ROM_SCAN_PINGPONG_EN
        expect_word(15); expect_word(14); expect_word(13);
`else
        expect_word(15); expect_word(0); expect_word(1);
`endif
        press(3, t);
        chk("auto_on", 32'(bus.auto_mode), 32'd1);
        wait_vld(base + 1, 1500, "auto_first_vld");
        idx = base;
        chk("auto_first_time", 32'(vld_cyc_q[idx] - t), 32'd1104);
        wait_vld(base + 3, 2500, "auto_three_vld");
        chk("auto_period_1", 32'(vld_cyc_q[idx + 1] - vld_cyc_q[idx]), 32'd1000);
        chk("auto_period_2", 32'(vld_cyc_q[idx + 2] - vld_cyc_q[idx + 1]), 32'd1000);
`ifdef ROM_SCAN_PINGPONG_EN
        chk("auto_dir", 32'(bus.dir_down), 32'd1);
        expect_word(12); expect_word(11);
`else
        chk("auto_dir", 32'(bus.dir_down), 32'd0);
        expect_word(0); expect_word(15);
`endif

        // key2 mid-period forces an immediate step down and restarts the timer.
        repeat (300) @(negedge clk);
        press(2, t);
        chk("auto_key_vld", 32'(vld_cnt), 32'(base + 4));
        chk("auto_key_latency", 32'(last_vld_cyc - t), 32'd104);
        chk("auto_key_dir", 32'(bus.dir_down), 32'd1);
        wait_vld(base + 5, 1500, "auto_after_key_vld");
        chk("auto_key_period", 32'(vld_cyc_q[idx + 4] - vld_cyc_q[idx + 3]), 32'd1000);

        press(3, t);
        chk("auto_off", 32'(bus.auto_mode), 32'd0);
        repeat (2500) @(negedge clk);
        chk("auto_off_quiet", 32'(vld_cnt), 32'(base + 5));

        // Reset one clock after a step request abandons the fetch.
        @(negedge clk);
        bus.key2 = 1'b0;
        t = cyc;
        repeat (101) @(negedge clk);
`ifdef ROM_SCAN_PINGPONG_EN
        chk("pre_reset_addr", 32'(bus.rom_addr), 32'd10);
`else
        chk("pre_reset_addr", 32'(bus.rom_addr), 32'd14);
`endif
        base = vld_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("mid_rst_disp_addr", 32'(bus.disp_addr), 32'd0);
        chk("mid_rst_disp_data", 32'(bus.disp_data), 32'd0);
        chk("mid_rst_dir", 32'(bus.dir_down), 32'd0);
        chk("mid_rst_auto", 32'(bus.auto_mode), 32'd0);
        bus.key2 = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_vld", 32'(vld_cnt), 32'(base));
        expect_word(0);
        rst_n = 1'b1;
        rel = cyc;
        wait_vld(base + 1, 20, "reboot_vld");
        chk("reboot_latency", 32'(last_vld_cyc - rel), 32'd3);
        repeat (20) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_scan_ctrl.md
# rom_scan_ctrl

Parametrised ROM browse controller that sits between the board keys and the display path (74HC595 serial driver) in the ROM demo designs. It debounces three active-low keys, steps a ROM read address manually or automatically at a fixed period, waits out the ROM read latency and presents the captured word with its address and a one-cycle valid strobe. It generalises the earlier two-key ROM demo with configurable depth, data width, read latency, auto-scan period and scan direction.

## Interface
- ADDR_W, 8: ROM address width
- DATA_W, 8: ROM data width
- DEPTH, 256: number of valid words, 2..2^ADDR_W; addresses DEPTH..2^ADDR_W-1 never driven
- CNT_MAX, 20'd999_999: debounce hold length in clocks (20 ms at 50 MHz); must be >= RD_LAT+3
- STEP_MAX, 24'd9_999_999: auto-step period minus one (200 ms at 50 MHz)
- RD_LAT, 1: ROM read latency in clocks, 1..3
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- key1  in  1  active-low, async to sys_clk: step up / set direction up
- key2  in  1  active-low: step down / set direction down
- key3  in  1  active-low: toggle manual/auto mode
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  DATA_W  ROM read data, valid RD_LAT clocks after rom_addr
- disp_addr  out  ADDR_W  address of the word in disp_data
- disp_data  out  DATA_W  captured ROM word
- disp_vld  out  1  one-cycle pulse: disp_addr/disp_data updated
- auto_mode  out  1  1 = auto-scan active
- dir_down  out  1  1 = current scan direction is down

## Operation
- Per key: 2-flop synchroniser; counter clears while synced key is high, increments while low, saturates at CNT_MAX; press pulse for exactly one cycle when counter == CNT_MAX-1. One pulse per press regardless of hold length or bounce shorter than CNT_MAX.
- key3 pulse: toggle auto_mode; clear step timer. Accepted in any FSM state.
- Manual mode: key1 pulse -> addr+1, key2 pulse -> addr-1; dir_down set to 0/1 respectively.
- Auto mode: step timer counts 0..STEP_MAX; at STEP_MAX one step in current direction, timer to 0. key1/key2 pulse sets direction, forces an immediate step in the new direction and clears the timer. Timer tick coincident with a key pulse yields a single step.
- key1 and key2 pulses in the same cycle: key1 wins.
- Wrap: DEPTH-1 +1 -> 0; 0 -1 -> DEPTH-1.
- FSM: IDLE (accept step requests) -> WAIT (rom_addr updated, count RD_LAT+1 clocks) -> LATCH (capture rom_data, pulse disp_vld) -> IDLE. Step requests arriving in WAIT or LATCH are dropped (timer still restarts).
- After reset release the FSM enters WAIT for address 0, so address 0 is displayed without a key press.

## Timing
- Reset values: rom_addr 0, disp_addr 0, disp_data 0, disp_vld 0, auto_mode 0, dir_down 0; FSM WAIT, all counters 0.
- Key low at pin -> press pulse after 2 (sync) + CNT_MAX-1 clocks.
- Press pulse at cycle P -> rom_addr new at P+1 -> disp_vld high in cycle P+RD_LAT+2 with disp_data = rom_data sampled on that edge, disp_addr = rom_addr.
- Auto steps separated by exactly STEP_MAX+1 clocks when undisturbed.
- Reset asserted mid-operation: all outputs to reset values immediately; an in-flight fetch is abandoned without disp_vld.

## Configuration
- ROM_SCAN_PINGPONG_EN defined: in auto mode, a step that would pass DEPTH-1 (up) or 0 (down) instead reverses dir_down and moves one word the other way (…, DEPTH-2, DEPTH-1, DEPTH-2, …). Manual stepping still wraps.
- Undefined: auto mode wraps exactly as manual mode.

## Test plan
Bench: CNT_MAX=99, STEP_MAX=999, RD_LAT=2, DEPTH=16, ROM[i]=8'hA0+i.
- Release reset, no keys -> single disp_vld 3 cycles after leaving reset, disp_addr 0, disp_data 8'hA0.
- key1 bounce (40/60/200/20 ns glitches) then held 3 µs -> exactly one step: rom_addr 1, disp_data 8'hA1, one disp_vld.
- Manual at addr 0, key2 press -> rom_addr 15, disp_data 8'hAF; then key1 press -> rom_addr 0.
- From addr 14, key3 press -> auto_mode 1; steps every 1000 clocks: 15, 0, 1 (macro undefined) or 15, 14, 13 with dir_down 1 (ROM_SCAN_PINGPONG_EN).
- Auto mode, key2 pulse mid-period -> immediate step down, dir_down 1, next step exactly 1000 clocks later; key3 again -> auto_mode 0, no further steps.
- Reset asserted 1 clock after a step request -> all outputs 0 at once, no disp_vld; after release address 0 re-fetched as in scenario 1.
